mult_share_sched: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/shift_add_mult_core.sv | 55 +++++
 rtl/mult_share_sched.sv | 113 +++++++++++
 tb/tb_mult_share_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and default widths for the shared multiplier scheduler
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int MULT_M = 8;
    localparam int MULT_N = 8;

endpackage

// File: rtl/shift_add_mult_core.sv
// rtl/shift_add_mult_core.sv - iterative shift-and-add multiplier, one multiplier bit per cycle
module shift_add_mult_core
    import mult_pkg::*;
#(
    parameter int M = MULT_M,
    parameter int N = MULT_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             done,
    output logic [M+N-1:0]   prod
);

    localparam int CW = $clog2(N + 1);

    logic [M+N-1:0] acc;
    logic [M+N-1:0] a_sh;
    logic [N-1:0]   b_sh;
    logic [CW-1:0]  cnt;
    logic           active;

    // Always runs the full N iterations, even for zero operands, so latency is fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            a_sh   <= {{N{1'b0}}, a};
            b_sh   <= b;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
                active <= 1'b0;
            end
        end
    end

    assign done = active && (cnt == CW'(N - 1));
    assign prod = acc;

endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin scheduler sharing one shift-and-add multiplier
module mult_share_sched
    import mult_pkg::*;
#(
    parameter int M    = MULT_M,
    parameter int N    = MULT_N,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*M-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [M+N-1:0]    rsp_prod,
    output logic              busy
);

    sched_state_t   state;
    sched_state_t   next_state;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] idx;
    logic           grant_found;
    logic           accept;
    logic           core_done;
    logic [M-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic [M+N-1:0] prod;

    // First valid requester at or after rr, wrapping upward.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr) + k) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*M +: M];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)    next_state = RUN;
            RUN:     if (core_done) next_state = DONE;
            DONE:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= '0;
            id    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                rr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                id <= grant;
            end
        end
    end

    shift_add_mult_core #(
        .M (M),
        .N (N)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .a     (sel_a),
        .b     (sel_b),
        .done  (core_done),
        .prod  (prod)
    );

    // The core's accumulator freezes once iteration ends, so it doubles as the response register.
    assign rsp_valid = (state == DONE);
    assign rsp_id    = id;
    assign rsp_prod  = prod;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - scoreboard bench for mult_share_sched
`timescale 1ns/1ps
module tb_mult_share_sched;

    localparam int M    = 8;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [M+N-1:0]    rsp_prod;
    logic              busy;

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    int   hs_cyc = 0;
    exp_t sb[$];
    int   acc_cyc[$];
    int   acc_id[$];

    mult_share_sched #(.M(M), .N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Observe handshakes mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot", 32'($countones(req_ready) <= 1), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{i, int'(req_a[i*M +: M]) * int'(req_b[i*N +: N])});
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(i);
                    n_acc++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc;
                n_rsp++;
                if (sb.size() == 0) begin
                    chk("sb_extra_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), e.id);
                    chk("rsp_prod", 32'(rsp_prod), e.prod);
                end
            end
        end
    end

    task automatic send(input int id, input int a, input int b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid[id]     = 1'b1;
        req_a[id*M +: M]  = a[M-1:0];
        req_b[id*N +: N]  = b[N-1:0];
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_timeout", 32'(ok), 1);
    endtask

    task automatic run_one(input int id, input int a, input int b);
        bit ok;
        rsp_ready = 1'b1;
        send(id, a, b);
        wait_rsp_valid(ok);
        if (ok) chk("latency", 32'(cyc - acc_cyc[$]), N + 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 32'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int base;
        int acc0;
        int rsp0;

        // Reset values, with requests already pending
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_prod", 32'(rsp_prod), 0);
        chk("rst_busy", 32'(busy), 0);

        // Fairness: all requesters held valid from reset
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*M +: M] = 8'(10 + i);
            req_b[i*N +: N] = 8'(20 + 3 * i);
        end
        rsp_ready = 1'b1;
        acc_cyc.delete();
        acc_id.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (acc_id.size() >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fair_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        req_valid = '0;
        if (ok) begin
            for (int g = 0; g < 5; g++) chk("fair_order", 32'(acc_id[g]), g % NREQ);
            for (int g = 1; g < 5; g++) chk("fair_spacing", 32'(acc_cyc[g] - acc_cyc[g-1]), N + 2);
        end
        drain();

        // Single request and operand extremes
        run_one(0, 13, 11);
        run_one(0, 255, 255);
        run_one(1, 0, 200);
        run_one(2, 1, 128);
        run_one(3, 200, 1);

        // Backpressure: hold the response, another requester waits
        rsp_ready = 1'b0;
        send(1, 77, 99);
        req_valid[3]     = 1'b1;
        req_a[3*M +: M]  = 8'd5;
        req_b[3*N +: N]  = 8'd6;
        wait_rsp_valid(ok);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_prod", 32'(rsp_prod), 77 * 99);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("bp_next_accept", 32'(acc_cyc[$] - hs_cyc), 1);
        chk("bp_next_id", 32'(acc_id[$]), 3);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        drain();

        // Reset mid-RUN; in-flight product from requester 2 is discarded
        send(2, 100, 100);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid[2]    = 1'b1;
        req_a[2*M +: M] = 8'd3;
        req_b[2*N +: N] = 8'd5;
        req_valid[3]    = 1'b1;
        req_a[3*M +: M] = 8'd9;
        req_b[3*N +: N] = 8'd9;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_prod", 32'(rsp_prod), 0);
        chk("mid_rst_id", 32'(rsp_id), 0);
        sb.delete();
        base = acc_id.size();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (acc_id.size() >= base + 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("post_rst_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        req_valid = '0;
        if (ok) begin
            chk("post_rst_first", 32'(acc_id[base]), 2);
            chk("post_rst_second", 32'(acc_id[base+1]), 3);
        end
        drain();

        // Random soak
        acc0 = n_acc;
        rsp0 = n_rsp;
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            req_a     = (NREQ*M)'($urandom);
            req_b     = (NREQ*N)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();
        chk("soak_sb_empty", 32'(sb.size()), 0);
        chk("soak_rsp_count", 32'(n_rsp - rsp0), 32'(n_acc - acc0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
